// File: rtl/pipe_arith_pkg.sv
// Shared constants for the chunked add/sub pipelines: chunk count, default
// chunk width and the two's-complement overflow helper.
package pipe_arith_pkg;
  localparam int NCHUNK      = 4;
  localparam int CHUNK_W_DEF = 32;

  // Subtract overflow: operand signs differ and result sign departs from minuend.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic ss);
    return (sa ^ sb) & (ss ^ sa);
  endfunction
endpackage

// File: rtl/pipe_sub_chunk.sv
// One pipeline stage: registered H-bit subtract a - b - bin with borrow out.
module pipe_sub_chunk #(
  parameter int H = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [H-1:0] i_a,
  input  logic [H-1:0] i_b,
  input  logic         i_bin,
  output logic [H-1:0] o_d,
  output logic         o_bout
);
  logic [H:0]   w_diff;
  logic [H-1:0] r_d;
  logic         r_bo;

  // Extra top bit of the widened difference is the borrow.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {{H{1'b0}}, i_bin};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_d  <= '0;
      r_bo <= 1'b0;
    end else if (en) begin
      r_d  <= w_diff[H-1:0];
      r_bo <= w_diff[H];
    end
  end

  assign o_d    = r_d;
  assign o_bout = r_bo;
endmodule

// File: rtl/pipe_sub_dly.sv
// Parameterized-depth register chain (DEPTH >= 1) used for operand skew and
// result deskew; advances only with en, cleared by synchronous active-low reset.
module pipe_sub_dly #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [DEPTH-1:0][W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else if (en) begin
      r_q[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_q[i] <= r_q[i-1];
    end
  end

  assign o_q = r_q[DEPTH-1];
endmodule

// File: rtl/pipe_sub_128.sv
// Four-stage chunked subtractor S = A - B, one H-bit chunk per stage with skewed
// inputs and deskewed outputs. Define PIPE_SUB_OVF_EN to add the signed ovf output.
module pipe_sub_128
  import pipe_arith_pkg::*;
#(
  parameter int H = CHUNK_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                in_valid,
  input  logic [NCHUNK*H-1:0] A,
  input  logic [NCHUNK*H-1:0] B,
  output logic [NCHUNK*H-1:0] S,
  output logic                bout,
  output logic                out_valid
`ifdef PIPE_SUB_OVF_EN
  ,
  output logic                ovf
`endif
);
  logic [NCHUNK-1:0][H-1:0] w_a, w_b, w_a_sk, w_b_sk, w_d, w_s;
  logic [NCHUNK:0]          w_bc;
  logic [NCHUNK-1:0]        r_vld_pipe;

  assign w_a     = A;
  assign w_b     = B;
  assign w_bc[0] = 1'b0;

  for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
    if (k == 0) begin : g_noskew
      assign w_a_sk[k] = w_a[k];
      assign w_b_sk[k] = w_b[k];
    end else begin : g_skew
      logic [2*H-1:0] w_q;
      pipe_sub_dly #(.W(2*H), .DEPTH(k)) u_skew (
        .clk(clk), .reset(reset), .en(en), .i_d({w_a[k], w_b[k]}), .o_q(w_q)
      );
      assign w_a_sk[k] = w_q[2*H-1:H];
      assign w_b_sk[k] = w_q[H-1:0];
    end

    // Borrow-in is the registered borrow of the previous chunk of the same op.
    pipe_sub_chunk #(.H(H)) u_stage (
      .clk(clk), .reset(reset), .en(en),
      .i_a(w_a_sk[k]), .i_b(w_b_sk[k]), .i_bin(w_bc[k]),
      .o_d(w_d[k]), .o_bout(w_bc[k+1])
    );

    if (k == NCHUNK-1) begin : g_nodeskew
      assign w_s[k] = w_d[k];
    end else begin : g_deskew
      pipe_sub_dly #(.W(H), .DEPTH(NCHUNK-1-k)) u_deskew (
        .clk(clk), .reset(reset), .en(en), .i_d(w_d[k]), .o_q(w_s[k])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)  r_vld_pipe <= '0;
    else if (en) r_vld_pipe <= {r_vld_pipe[NCHUNK-2:0], in_valid};
  end

  assign S         = w_s;
  assign bout      = w_bc[NCHUNK];
  assign out_valid = r_vld_pipe[NCHUNK-1];

`ifdef PIPE_SUB_OVF_EN
  // Operand signs ride alongside the top chunk so ovf lines up with S.
  logic r_sa, r_sb;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sa <= 1'b0;
      r_sb <= 1'b0;
    end else if (en) begin
      r_sa <= w_a_sk[NCHUNK-1][H-1];
      r_sb <= w_b_sk[NCHUNK-1][H-1];
    end
  end

  assign ovf = sub_ovf(r_sa, r_sb, w_s[NCHUNK-1][H-1]);
`endif
endmodule

// File: tb/tb_pipe_sub_128.sv
// Bench for pipe_sub_128 at H=4: vector table plus multi-cycle sequences, checked
// through an expected-result queue tagged with the enabled cycle each result is due.
module tb_pipe_sub_128;
  import pipe_arith_pkg::*;
  localparam int H = 4;
  localparam int W = NCHUNK*H;

  logic         clk = 1'b0, reset = 1'b0, en = 1'b0, in_valid = 1'b0;
  logic [W-1:0] A = '0, B = '0, S;
  logic         bout, out_valid;
`ifdef PIPE_SUB_OVF_EN
  logic         ovf;
`endif

  pipe_sub_128 #(.H(H)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
    .A(A), .B(B), .S(S), .bout(bout), .out_valid(out_valid)
`ifdef PIPE_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] a, b, s; logic bo, ov; } vec_t;
  typedef struct { logic [W-1:0] s; logic bo, ov; int due; } exp_t;

  vec_t   tv[11];
  exp_t   q[$];
  exp_t   nxt, cur;
  logic   cur_v = 1'b0;
  int     checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at enabled cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.s   = a - b;
    e.bo  = (a < b);
    e.ov  = (a[W-1] != b[W-1]) && (e.s[W-1] != a[W-1]);
    e.due = 0;
    return e;
  endfunction

  // One clock edge: enqueue what the DUT accepts, then compare after the edge.
  task automatic step();
    logic rst, adv;
    exp_t e;
    rst = !reset;
    adv = en && reset;
    if (adv && in_valid) begin
      e     = nxt;
      e.due = cyc + 4;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      cur_v  = 1'b0;
      cur.s  = '0;
      cur.bo = 1'b0;
      cur.ov = 1'b0;
    end else if (adv) begin
      cyc++;
      if (q.size() > 0 && q[0].due == cyc) begin
        cur   = q.pop_front();
        cur_v = 1'b1;
      end else begin
        cur_v = 1'b0;
      end
    end
    chk("out_valid", 32'(out_valid), 32'(cur_v));
    if (cur_v || rst) begin
      chk("S", 32'(S), 32'(cur.s));
      chk("bout", 32'(bout), 32'(cur.bo));
`ifdef PIPE_SUB_OVF_EN
      chk("ovf", 32'(ovf), 32'(cur.ov));
`endif
    end
  endtask

  task automatic put(input logic [W-1:0] a, input logic [W-1:0] b, input logic v);
    A = a; B = b; in_valid = v;
    nxt = model(a, b);
    step();
  endtask

  initial begin
    tv[0]  = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    tv[1]  = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0};
    tv[2]  = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
    tv[3]  = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
    tv[4]  = '{16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0};
    tv[5]  = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    tv[6]  = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tv[7]  = '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0};
    tv[8]  = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
    tv[9]  = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0};
    tv[10] = '{16'h1234, 16'h0FFF, 16'h0235, 1'b0, 1'b0};

    // Reset with en low must still clear, then with en high.
    reset = 1'b0; en = 1'b0; A = 16'hFFFF; B = 16'h1234; in_valid = 1'b1;
    step();
    en = 1'b1;
    step();
    reset = 1'b1; in_valid = 1'b0;

    // Table vectors back to back, one per enabled cycle.
    for (int i = 0; i < 11; i++) begin
      A = tv[i].a; B = tv[i].b; in_valid = 1'b1;
      nxt.s = tv[i].s; nxt.bo = tv[i].bo; nxt.ov = tv[i].ov;
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();

    // Bubbles between valid operations; data still moves with in_valid low.
    for (int i = 0; i < 8; i++) put(16'(i * 16'h1111), 16'(16'h2345 + i), (i % 2) == 0);
    in_valid = 1'b0;
    repeat (6) step();

    // Stall three cycles mid-flight; outputs must hold.
    put(16'h0100, 16'h0001, 1'b1);
    put(16'h0003, 16'h0005, 1'b1);
    put(16'h8000, 16'h0001, 1'b1);
    en = 1'b0;
    put(16'hDEAD, 16'hBEEF, 1'b1);
    put(16'hDEAD, 16'hBEEF, 1'b1);
    put(16'hDEAD, 16'hBEEF, 1'b1);
    en = 1'b1;
    put(16'hF000, 16'h0F00, 1'b1);
    in_valid = 1'b0;
    repeat (6) step();

    // Reset with three operations in flight; nothing stale may appear after.
    put(16'h0000, 16'h0001, 1'b1);
    put(16'h1111, 16'h2222, 1'b1);
    put(16'h4444, 16'h3333, 1'b1);
    reset = 1'b0; in_valid = 1'b0;
    step();
    reset = 1'b1;
    repeat (6) step();
    put(16'h0005, 16'h0003, 1'b1);
    in_valid = 1'b0;
    repeat (6) step();

    // Random traffic with random enable gaps.
    for (int i = 0; i < 80; i++) begin
      en = ($urandom_range(0, 3) != 0);
      put(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    en = 1'b1; in_valid = 1'b0;
    repeat (8) step();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_sub_128.md
PIPE_SUB_128 -- requirements
Module: pipe_sub_128

Interface
REQ-001 SHALL have parameter: H, 32, chunk width in bits; operand width is 4*H, split into 4 chunks.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: en  input  1  pipeline advance enable.
REQ-005 SHALL have port: in_valid  input  1  qualifies A/B this cycle.
REQ-006 SHALL have port: A  input  4*H  minuend, unsigned, bit 0 = LSB.
REQ-007 SHALL have port: B  input  4*H  subtrahend, unsigned.
REQ-008 SHALL have port: S  output  4*H  difference A-B mod 2^(4H).
REQ-009 SHALL have port: bout  output  1  borrow out, 1 when A<B unsigned.
REQ-010 SHALL have port: out_valid  output  1  qualifies S/bout (and ovf).

Function
REQ-011 SHALL compute one H-bit chunk per stage: stage k (k=0..3) subtracts chunk k of A and B with a registered borrow-in from stage k-1; stage 0 borrow-in is 0.
REQ-012 SHALL skew inputs: chunk k of A and B delayed k enabled cycles before stage k.
REQ-013 SHALL deskew outputs: chunk k result delayed 3-k enabled cycles after stage k, so all chunks of one operation reach S together.
REQ-014 SHALL have latency exactly 4 enabled cycles: operands sampled at edge t (en=1, in_valid=1) appear on S/bout/out_valid after edge t+4.
REQ-015 SHALL accept a new operation every enabled cycle (throughput 1/cycle); back-to-back operations SHALL NOT interfere.
REQ-016 SHALL carry in_valid through a 4-deep valid shift register aligned with the data; out_valid=0 bubbles SHALL propagate unchanged.
REQ-017 SHALL propagate chunk borrows per operation only: no borrow leaks between consecutive operations.
REQ-018 SHALL freeze all pipeline registers (data, borrows, valids) when en=0; outputs hold their values.
REQ-019 SHALL keep data registers updating when in_valid=0 and en=1; values with out_valid=0 are don't-care.
REQ-020 SHALL assert bout equal to the stage-3 borrow-out of the same operation.

Reset
REQ-021 SHALL, on rising clk with reset=0, clear all data, borrow and valid registers to 0, regardless of en.
REQ-022 SHALL drive S=0, bout=0 and out_valid=0 (and ovf=0) from the first edge with reset low.
REQ-023 SHALL discard in-flight operations on reset mid-operation; the first valid output after release SHALL come 4 enabled cycles after the first accepted input.

Configuration
REQ-024 SHALL, when macro PIPE_SUB_OVF_EN is defined, add output ovf (1 bit): two's-complement overflow of A-B, i.e. the sign bits of A and B differ and the sign of S differs from A; ovf is aligned with S and qualified by out_valid.
REQ-025 SHALL, when PIPE_SUB_OVF_EN is undefined, omit the ovf port and its logic entirely; all other behaviour SHALL be identical.

Structure
REQ-026 SHALL take the chunk count constant (NCHUNK=4) and the default chunk width from shared package pipe_arith_pkg, which is also used by the adder pipeline.
REQ-027 SHALL implement each stage as sub-module pipe_sub_chunk: an H-bit registered subtract with borrow in/out, en and synchronous active-low reset.
REQ-028 SHALL build the skew and deskew delay lines as parameterized-depth register chains that honour en and reset.

Verification (bench H=4, 16-bit operands)
REQ-029 SHALL cover: A=16'h0000, B=16'h0001, in_valid=1 at edge t -> after edge t+4: S=16'hFFFF, bout=1, out_valid=1.
REQ-030 SHALL cover: A=16'h1000, B=16'h0001 (borrow ripples through chunks 0-2) -> S=16'h0FFF, bout=0.
REQ-031 SHALL cover: back-to-back inputs (5,3), (3,5), (16'hABCD,16'hABCD) on consecutive edges -> outputs 16'h0002/bout 0, 16'hFFFE/bout 1, 16'h0000/bout 0 on consecutive cycles.
REQ-032 SHALL cover: en=0 for 3 cycles mid-flight -> outputs hold; results appear after 4 enabled cycles with correct values.
REQ-033 SHALL cover: reset=0 for one edge with 3 operations in flight -> out_valid=0, S=0 immediately; no stale result ever emerges.
REQ-034 SHALL cover, with PIPE_SUB_OVF_EN defined: A=16'h8000, B=16'h0001 -> S=16'h7FFF, ovf=1, bout=0; with A=16'h0005, B=16'h0003 -> ovf=0.
